// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding valid/ready slave with programmable wait states,
// byte-lane masked stores and sign/zero-extending loads.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [1:0]  dmwr,
  input  logic [2:0]  dmre,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_LAST = WAIT_CYCLES[3:0];

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W+1:0] r_addr;
  logic [1:0]        r_dmwr;
  logic [2:0]        r_dmre;
  logic [31:0]       r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rdata;
  logic              r_rsp_err;
  logic [31:0]       r_mem [DEPTH];

  // Decode acts on the live inputs while idle and on the latched request afterwards,
  // so a zero-wait request can be answered from the accept edge.
  logic              w_idle;
  logic [ADDR_W+1:0] w_addr;
  logic [1:0]        w_dmwr;
  logic [2:0]        w_dmre;
  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lane;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_is_word;
  logic              w_is_half;
  logic              w_err;
  logic [31:0]       w_load;
  logic              w_unused_addr;

  assign w_idle        = (r_state == S_IDLE);
  assign w_addr        = w_idle ? addr[ADDR_W+1:0] : r_addr;
  assign w_dmwr        = w_idle ? dmwr : r_dmwr;
  assign w_dmre        = w_idle ? dmre : r_dmre;
  assign w_idx         = w_addr[ADDR_W+1:2];
  assign w_lane        = w_addr[1:0];
  assign w_word        = r_mem[w_idx];
  assign w_half        = w_lane[1] ? w_word[31:16] : w_word[15:0];
  assign w_unused_addr = ^addr[31:ADDR_W+2];

  always_comb begin
    w_byte = w_word[7:0];
    case (w_lane)
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  assign w_is_word = (w_dmwr == 2'b01) || (w_dmre == 3'b001);
  assign w_is_half = (w_dmwr == 2'b10) || (w_dmre == 3'b010) || (w_dmre == 3'b011);
  assign w_err     = (w_is_word && (w_lane != 2'b00))
                   || (w_is_half && w_lane[0])
                   || ((w_dmwr != 2'b00) && (w_dmre != 3'b000))
                   || (w_dmre[2:1] == 2'b11);

  always_comb begin
    w_load = 32'd0;
    if (!w_err) begin
      case (w_dmre)
        3'b001:  w_load = w_word;
        3'b010:  w_load = {{16{w_half[15]}}, w_half};
        3'b011:  w_load = {16'd0, w_half};
        3'b100:  w_load = {{24{w_byte[7]}}, w_byte};
        3'b101:  w_load = {24'd0, w_byte};
        default: w_load = 32'd0;
      endcase
    end
  end

  // Store lanes: data is replicated across lanes, the enables pick the target bytes.
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic        w_we;

  always_comb begin
    w_be        = 4'b0000;
    w_wdata_rep = r_wdata;
    case (r_dmwr)
      2'b01: w_be = 4'b1111;
      2'b10: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      2'b11: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      default: w_be = 4'b0000;
    endcase
  end

  assign w_we = rst && (r_state == S_RESP) && !r_rsp_err;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_we && w_be[b]) begin
        r_mem[r_addr[ADDR_W+1:2]][8*b +: 8] <= w_wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_dmwr      <= 2'b00;
      r_dmre      <= 3'b000;
      r_wdata     <= 32'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr      <= addr[ADDR_W+1:0];
            r_dmwr      <= dmwr;
            r_dmre      <= dmre;
            r_wdata     <= wdata;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rdata     <= w_load;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt + 4'd1 == WAIT_LAST) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rdata     <= w_load;
            r_rsp_err   <= w_err;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rdata     = r_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
